// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, almost thresholds and overflow/underflow pulses.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   data_in, wr_en   write word / push request
//   rd_en            pop request (acknowledge of shown word in FWFT)
//   data_out         read word
//   FIFO_empty/full  count == 0 / count == DEPTH
//   almost_full      count >= AFULL_THRESH
//   almost_empty     count <= AEMPTY_THRESH
//   count            words stored
//   overflow         pulse: previous edge rejected a write
//   underflow        pulse: previous edge rejected a read
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  FIFO_empty,
    output logic                  FIFO_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C =
        (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C =
        (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C =
        (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE =
        (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;

    logic wr_acc;
    logic rd_acc;
    logic ptr_empty;
    logic ptr_full;

    assign waddr = wptr[ADDR_WIDTH-1:0];
    assign raddr = rptr[ADDR_WIDTH-1:0];

    assign FIFO_empty   = (count == '0);
    assign FIFO_full    = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // No pass-through: full blocks writes and
    // empty blocks reads regardless of the
    // other side in the same cycle.
    assign wr_acc = wr_en && !FIFO_full;
    assign rd_acc = rd_en && !FIFO_empty;

    // Extra-MSB pointer view of occupancy; must
    // track the count-based flags exactly.
    assign ptr_empty = (wptr == rptr);
    assign ptr_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH])
                    && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[waddr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && FIFO_full;
            underflow <= rd_en && FIFO_empty;
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + ONE;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown as soon as it exists;
            // rd_en only pops it.
            assign data_out = FIFO_empty ? '0 : mem[raddr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[raddr];
                end
            end

            assign data_out = rd_q;
        end
    endgenerate

    a_ptr_agree: assert property (
        @(posedge clk) disable iff (rst)
        (ptr_empty == FIFO_empty) && (ptr_full == FIFO_full)
    );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: one standard-read
// and one FWFT instance, DEPTH=4, thresholds 3/1.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // standard-read instance
    logic       s_rst, s_wr, s_rd;
    logic [7:0] s_din, s_dout;
    logic       s_empty, s_full, s_af, s_ae, s_ov, s_un;
    logic [2:0] s_cnt;

    // FWFT instance
    logic       f_rst, f_wr, f_rd;
    logic [7:0] f_din, f_dout;
    logic       f_empty, f_full, f_af, f_ae, f_ov, f_un;
    logic [2:0] f_cnt;

    sync_fifo_flex #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0),
        .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) u_std (
        .clk(clk), .rst(s_rst), .data_in(s_din),
        .wr_en(s_wr), .rd_en(s_rd), .data_out(s_dout),
        .FIFO_empty(s_empty), .FIFO_full(s_full),
        .almost_full(s_af), .almost_empty(s_ae),
        .count(s_cnt), .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_flex #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1),
        .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) u_fw (
        .clk(clk), .rst(f_rst), .data_in(f_din),
        .wr_en(f_wr), .rd_en(f_rd), .data_out(f_dout),
        .FIFO_empty(f_empty), .FIFO_full(f_full),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_cnt), .overflow(f_ov), .underflow(f_un)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // count, empty, full, af, ae, ov, un in one go
    task automatic s_flags(input string tag,
                           input int c,
                           input logic e, input logic f,
                           input logic af, input logic ae,
                           input logic ov, input logic un);
        chk({tag, ".cnt"}, 32'(s_cnt), 32'(c));
        chk({tag, ".emp"}, 32'(s_empty), 32'(e));
        chk({tag, ".ful"}, 32'(s_full), 32'(f));
        chk({tag, ".af"}, 32'(s_af), 32'(af));
        chk({tag, ".ae"}, 32'(s_ae), 32'(ae));
        chk({tag, ".ov"}, 32'(s_ov), 32'(ov));
        chk({tag, ".un"}, 32'(s_un), 32'(un));
    endtask

    initial begin
        s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
        f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
        tick();
        s_flags("rst", 0, 1, 0, 0, 1, 0, 0);
        chk("rst.dout", 32'(s_dout), 32'h0);
        chk("frst.emp", 32'(f_empty), 32'd1);
        chk("frst.dout", 32'(f_dout), 32'h0);
        s_rst = 1'b0;
        f_rst = 1'b0;

        // 1: fill to full, then overflow
        s_wr = 1'b1;
        s_din = 8'h11; tick();
        s_flags("w1", 1, 0, 0, 0, 1, 0, 0);
        s_din = 8'h22; tick();
        s_flags("w2", 2, 0, 0, 0, 0, 0, 0);
        s_din = 8'h33; tick();
        s_flags("w3", 3, 0, 0, 1, 0, 0, 0);
        s_din = 8'h44; tick();
        s_flags("w4", 4, 0, 1, 1, 0, 0, 0);
        s_din = 8'h55; tick();
        s_flags("w5", 4, 0, 1, 1, 0, 1, 0);
        s_wr = 1'b0; tick();
        s_flags("w6", 4, 0, 1, 1, 0, 0, 0);

        // 2: drain in order, then underflow
        s_rd = 1'b1;
        tick(); chk("r1", 32'(s_dout), 32'h11);
        tick(); chk("r2", 32'(s_dout), 32'h22);
        tick(); chk("r3", 32'(s_dout), 32'h33);
        tick(); chk("r4", 32'(s_dout), 32'h44);
        s_flags("r4", 0, 1, 0, 0, 1, 0, 0);
        tick();
        s_flags("r5", 0, 1, 0, 0, 1, 0, 1);
        chk("r5.hold", 32'(s_dout), 32'h44);
        s_rd = 1'b0; tick();
        chk("r6.un", 32'(s_un), 32'd0);

        // 4: count=2, streaming through wrap
        s_wr = 1'b1;
        s_din = 8'h00; tick();
        s_din = 8'h01; tick();
        s_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_din = 8'(i + 2);
            tick();
            chk($sformatf("strm%0d.cnt", i), 32'(s_cnt), 32'd2);
            chk($sformatf("strm%0d.dat", i), 32'(s_dout), 32'(i));
        end
        // FIFO now holds 0x0A, 0x0B
        s_rd = 1'b0;

        // 5: full with simultaneous wr/rd
        s_din = 8'h20; tick();
        s_din = 8'h21; tick();
        chk("p5.full", 32'(s_full), 32'd1);
        s_rd = 1'b1; s_din = 8'h99; tick();
        s_flags("p5.fwr", 3, 0, 0, 1, 0, 1, 0);
        chk("p5.fdat", 32'(s_dout), 32'h0A);
        s_wr = 1'b0;
        tick(); chk("p5.d1", 32'(s_dout), 32'h0B);
        tick(); chk("p5.d2", 32'(s_dout), 32'h20);
        tick(); chk("p5.d3", 32'(s_dout), 32'h21);
        chk("p5.emp", 32'(s_empty), 32'd1);
        s_wr = 1'b1; s_din = 8'h66; tick();
        s_flags("p5.ewr", 1, 0, 0, 0, 1, 0, 1);
        chk("p5.hold", 32'(s_dout), 32'h21);
        s_rd = 1'b0;

        // 6: reset mid-operation with a write pending
        s_din = 8'h67; tick();
        s_din = 8'h68; tick();
        chk("p6.pre", 32'(s_cnt), 32'd3);
        s_rst = 1'b1; s_din = 8'hEE; tick();
        s_flags("p6.rst", 0, 1, 0, 0, 1, 0, 0);
        chk("p6.dout", 32'(s_dout), 32'h0);
        s_rst = 1'b0; s_din = 8'h7E; tick();
        chk("p6.w", 32'(s_cnt), 32'd1);
        s_wr = 1'b0; s_rd = 1'b1; tick();
        chk("p6.rd", 32'(s_dout), 32'h7E);
        chk("p6.emp", 32'(s_empty), 32'd1);
        s_rd = 1'b0;

        // 3: FWFT fall-through and pop
        f_wr = 1'b1; f_din = 8'hA5; tick();
        chk("f3.emp", 32'(f_empty), 32'd0);
        chk("f3.dat", 32'(f_dout), 32'hA5);
        f_wr = 1'b0; tick();
        chk("f3.keep", 32'(f_dout), 32'hA5);
        f_rd = 1'b1; tick();
        chk("f3.pemp", 32'(f_empty), 32'd1);
        chk("f3.pdat", 32'(f_dout), 32'h00);
        tick();
        chk("f3.un", 32'(f_un), 32'd1);
        f_rd = 1'b0;

        // FWFT streaming at count=2
        f_wr = 1'b1;
        f_din = 8'h00; tick();
        chk("f4.head", 32'(f_dout), 32'h00);
        f_din = 8'h01; tick();
        f_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f_din = 8'(i + 2);
            tick();
            chk($sformatf("fs%0d.cnt", i), 32'(f_cnt), 32'd2);
            chk($sformatf("fs%0d.dat", i), 32'(f_dout),
                32'(i + 1));
        end
        // holds 0x0A, 0x0B; pop one to reach count=1
        f_wr = 1'b0; tick();
        chk("f5.dat", 32'(f_dout), 32'h0B);
        chk("f5.cnt", 32'(f_cnt), 32'd1);
        f_wr = 1'b1; f_din = 8'h5A; tick();
        chk("f5.nxt", 32'(f_dout), 32'h5A);
        chk("f5.c1", 32'(f_cnt), 32'd1);
        f_wr = 1'b0; tick();
        chk("f5.emp", 32'(f_empty), 32'd1);
        chk("f5.z", 32'(f_dout), 32'h00);
        f_rd = 1'b0;

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
